cdb_reservation_station: RTL and testbench

Reservation station on the consumer side of the Common Data Bus. Holds dispatched instructions whose source operands may still be in flight. Snoops every CDB broadcast to capture operand values by tag. Hands fully-ready instructions to an execution unit through a valid/ready issue handshake. One instance sits in front of each execution unit whose results the CDB arbiter later collects.

---
 rtl/cdb_reservation_station.sv | 155 +++++++++++++++
 tb/tb_cdb_reservation_station.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_reservation_station.sv
// Reservation station that snoops the Common Data Bus for operand values and
// issues fully-ready instructions, lowest index first, over a valid/ready handshake.
module cdb_reservation_station #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_WIDTH   = 6,
    parameter int OP_WIDTH    = 4,
    parameter int CNT_WIDTH   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [OP_WIDTH-1:0]  disp_op,
    input  logic [TAG_WIDTH-1:0] disp_dest_tag,
    input  logic                 disp_src1_rdy,
    input  logic                 disp_src2_rdy,
    input  logic [TAG_WIDTH-1:0] disp_src1_tag,
    input  logic [TAG_WIDTH-1:0] disp_src2_tag,
    input  logic [31:0]          disp_src1_data,
    input  logic [31:0]          disp_src2_data,
    input  logic                 cdb_valid,
    input  logic [TAG_WIDTH-1:0] cdb_tag,
    input  logic [31:0]          cdb_data,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [OP_WIDTH-1:0]  issue_op,
    output logic [TAG_WIDTH-1:0] issue_dest_tag,
    output logic [31:0]          issue_src1,
    output logic [31:0]          issue_src2,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef struct packed {
        logic                 valid;
        logic [OP_WIDTH-1:0]  op;
        logic [TAG_WIDTH-1:0] dest_tag;
        logic                 s1_rdy;
        logic [TAG_WIDTH-1:0] s1_tag;
        logic [31:0]          s1_data;
        logic                 s2_rdy;
        logic [TAG_WIDTH-1:0] s2_tag;
        logic [31:0]          s2_data;
    } entry_t;

    entry_t [NUM_ENTRIES-1:0] ent_q, ent_d;
    logic   [CNT_WIDTH-1:0]   count_q, count_d;

    logic             any_free, any_rdy;
    logic [IDX_W-1:0] free_idx, issue_idx;
    logic             disp_fire, issue_fire;
    entry_t           new_ent;

    // Priority pickers: scanning downward leaves the lowest qualifying index.
    // NOTE: always_comb uses blocking (=) assignments and gives every output a
    // default first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        any_free  = 1'b0;
        free_idx  = '0;
        any_rdy   = 1'b0;
        issue_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (ent_q[i].valid && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
                any_rdy   = 1'b1;
                issue_idx = IDX_W'(i);
            end
        end
    end

    assign disp_ready  = any_free && !flush;
    assign issue_valid = any_rdy && !flush;
    assign disp_fire   = disp_valid && disp_ready;
    assign issue_fire  = issue_valid && issue_ready;
    assign count       = count_q;

    always_comb begin
        issue_op       = '0;
        issue_dest_tag = '0;
        issue_src1     = '0;
        issue_src2     = '0;
        if (issue_valid) begin
            issue_op       = ent_q[issue_idx].op;
            issue_dest_tag = ent_q[issue_idx].dest_tag;
            issue_src1     = ent_q[issue_idx].s1_data;
            issue_src2     = ent_q[issue_idx].s2_data;
        end
    end

    // Incoming entry, with a same-cycle CDB hit captured as a dispatch bypass.
    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.op       = disp_op;
        new_ent.dest_tag = disp_dest_tag;
        new_ent.s1_rdy   = disp_src1_rdy;
        new_ent.s1_tag   = disp_src1_tag;
        new_ent.s1_data  = disp_src1_data;
        new_ent.s2_rdy   = disp_src2_rdy;
        new_ent.s2_tag   = disp_src2_tag;
        new_ent.s2_data  = disp_src2_data;
        if (cdb_valid && !disp_src1_rdy && (cdb_tag == disp_src1_tag)) begin
            new_ent.s1_rdy  = 1'b1;
            new_ent.s1_data = cdb_data;
        end
        if (cdb_valid && !disp_src2_rdy && (cdb_tag == disp_src2_tag)) begin
            new_ent.s2_rdy  = 1'b1;
            new_ent.s2_data = cdb_data;
        end
    end

    always_comb begin
        ent_d   = ent_q;
        count_d = count_q + CNT_WIDTH'(disp_fire) - CNT_WIDTH'(issue_fire);
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cdb_valid && ent_q[i].valid) begin
                if (!ent_q[i].s1_rdy && (ent_q[i].s1_tag == cdb_tag)) begin
                    ent_d[i].s1_rdy  = 1'b1;
                    ent_d[i].s1_data = cdb_data;
                end
                if (!ent_q[i].s2_rdy && (ent_q[i].s2_tag == cdb_tag)) begin
                    ent_d[i].s2_rdy  = 1'b1;
                    ent_d[i].s2_data = cdb_data;
                end
            end
        end
        // The issued slot is always valid and the dispatch slot always invalid,
        // so the two updates never touch the same entry.
        if (issue_fire) ent_d[issue_idx].valid = 1'b0;
        if (disp_fire)  ent_d[free_idx] = new_ent;
        if (flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_d[i].valid = 1'b0;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values. The entry array is flop-based, so it is reset as a whole;
    // payload fields are don't-care once valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q   <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_cdb_reservation_station.sv
// Directed bench for cdb_reservation_station: hand-computed vectors covering
// issue, wakeup, bypass, full/backpressure, shared-tag wakeup, flush and reset.
module tb_cdb_reservation_station;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [3:0]  disp_op = '0;
    logic [5:0]  disp_dest_tag = '0;
    logic        disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
    logic [5:0]  disp_src1_tag = '0, disp_src2_tag = '0;
    logic [31:0] disp_src1_data = '0, disp_src2_data = '0;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [3:0]  issue_op;
    logic [5:0]  issue_dest_tag;
    logic [31:0] issue_src1, issue_src2;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    cdb_reservation_station #(
        .NUM_ENTRIES(4), .TAG_WIDTH(6), .OP_WIDTH(4), .CNT_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_dest_tag(disp_dest_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_data(disp_src1_data), .disp_src2_data(disp_src2_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_dest_tag(issue_dest_tag),
        .issue_src1(issue_src1), .issue_src2(issue_src2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [3:0] op, input logic [5:0] dest,
                            input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                            input logic r2, input logic [5:0] t2, input logic [31:0] d2);
        disp_valid     = 1'b1;
        disp_op        = op;
        disp_dest_tag  = dest;
        disp_src1_rdy  = r1;
        disp_src1_tag  = t1;
        disp_src1_data = d1;
        disp_src2_rdy  = r2;
        disp_src2_tag  = t2;
        disp_src2_data = d2;
    endtask

    task automatic set_cdb(input logic v, input logic [5:0] t, input logic [31:0] d);
        cdb_valid = v;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_issue_src1", issue_src1, 32'd0);
        check("rst_issue_dest", 32'(issue_dest_tag), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_disp_ready", 32'(disp_ready), 32'd1);

        // Both operands ready: eligible the cycle after dispatch
        set_disp(4'd3, 6'd5, 1'b1, 6'd0, 32'd10, 1'b1, 6'd0, 32'd20);
        #1;
        check("t1_no_same_cycle_issue", 32'(issue_valid), 32'd0);
        tick();
        disp_valid = 1'b0;
        check("t1_issue_valid", 32'(issue_valid), 32'd1);
        check("t1_issue_op", 32'(issue_op), 32'd3);
        check("t1_issue_dest", 32'(issue_dest_tag), 32'd5);
        check("t1_issue_src1", issue_src1, 32'd10);
        check("t1_issue_src2", issue_src2, 32'd20);
        check("t1_count", 32'(count), 32'd1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("t1_count_after_issue", 32'(count), 32'd0);
        check("t1_idle_valid", 32'(issue_valid), 32'd0);
        check("t1_idle_src1_zero", issue_src1, 32'd0);

        // src1 waits on tag 7; tag 8 must not wake it
        set_disp(4'd1, 6'd2, 1'b0, 6'd7, 32'd0, 1'b1, 6'd0, 32'd5);
        tick();
        disp_valid = 1'b0;
        check("t2_waiting", 32'(issue_valid), 32'd0);
        set_cdb(1'b1, 6'd8, 32'h1111);
        tick();
        set_cdb(1'b0, 6'd0, 32'd0);
        #1;
        check("t2_wrong_tag_still_waiting", 32'(issue_valid), 32'd0);
        set_cdb(1'b1, 6'd7, 32'hDEAD);
        #1;
        check("t2_no_wake_in_bcast_cycle", 32'(issue_valid), 32'd0);
        tick();
        set_cdb(1'b0, 6'd0, 32'd0);
        check("t2_woken_valid", 32'(issue_valid), 32'd1);
        check("t2_woken_src1", issue_src1, 32'hDEAD);
        check("t2_woken_src2", issue_src2, 32'd5);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("t2_count", 32'(count), 32'd0);

        // Dispatch bypass: CDB tag 9 in the dispatch cycle
        set_disp(4'd2, 6'd3, 1'b1, 6'd0, 32'd1, 1'b0, 6'd9, 32'd0);
        set_cdb(1'b1, 6'd9, 32'd42);
        tick();
        disp_valid = 1'b0;
        set_cdb(1'b0, 6'd0, 32'd0);
        check("t3_bypass_valid", 32'(issue_valid), 32'd1);
        check("t3_bypass_src2", issue_src2, 32'd42);
        check("t3_bypass_dest", 32'(issue_dest_tag), 32'd3);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("t3_count", 32'(count), 32'd0);

        // Fill all four slots (dest 20..23) with issue backpressured
        for (int i = 0; i < 4; i++) begin
            set_disp(4'd4, 6'(20 + i), 1'b1, 6'd0, 32'(100 + i), 1'b1, 6'd0, 32'd0);
            tick();
        end
        disp_valid = 1'b0;
        #1;
        check("t4_full_count", 32'(count), 32'd4);
        check("t4_full_disp_ready", 32'(disp_ready), 32'd0);
        check("t4_present_slot0", 32'(issue_dest_tag), 32'd20);
        set_disp(4'd4, 6'd30, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
        tick();
        disp_valid = 1'b0;
        check("t4_extra_ignored", 32'(count), 32'd4);
        check("t4_stable_while_stalled", 32'(issue_dest_tag), 32'd20);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("t4_count_after_issue", 32'(count), 32'd3);
        check("t4_ready_after_issue", 32'(disp_ready), 32'd1);
        check("t4_present_slot1", 32'(issue_dest_tag), 32'd21);
        // Dispatch dest 24 into slot 0 while slot 1 issues
        set_disp(4'd4, 6'd24, 1'b1, 6'd0, 32'd124, 1'b1, 6'd0, 32'd0);
        issue_ready = 1'b1;
        tick();
        disp_valid  = 1'b0;
        issue_ready = 1'b0;
        check("t4_disp_and_issue_count", 32'(count), 32'd3);
        check("t4_new_slot0_present", 32'(issue_dest_tag), 32'd24);
        check("t4_new_slot0_src1", issue_src1, 32'd124);
        set_disp(4'd4, 6'd25, 1'b1, 6'd0, 32'd125, 1'b1, 6'd0, 32'd0);
        tick();
        disp_valid = 1'b0;
        check("t4_refill_count", 32'(count), 32'd4);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("t4_three_left", 32'(count), 32'd3);

        // Flush with a dispatch request and ready entries present
        flush = 1'b1;
        set_disp(4'd5, 6'd40, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
        #1;
        check("t6_flush_blocks_disp", 32'(disp_ready), 32'd0);
        check("t6_flush_blocks_issue", 32'(issue_valid), 32'd0);
        check("t6_flush_zero_data", issue_src1, 32'd0);
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        #1;
        check("t6_flush_count", 32'(count), 32'd0);
        check("t6_flush_issue_valid", 32'(issue_valid), 32'd0);
        check("t6_flush_disp_ready", 32'(disp_ready), 32'd1);

        // Slots 0/2 wait on other tags; slots 1/3 share tag 12
        set_disp(4'd6, 6'd40, 1'b0, 6'd50, 32'd0, 1'b1, 6'd0, 32'd0);
        tick();
        set_disp(4'd6, 6'd41, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'hA);
        tick();
        set_disp(4'd6, 6'd42, 1'b1, 6'd0, 32'd0, 1'b0, 6'd51, 32'd0);
        tick();
        set_disp(4'd7, 6'd43, 1'b1, 6'd0, 32'hB, 1'b0, 6'd12, 32'd0);
        tick();
        disp_valid = 1'b0;
        check("t5_count", 32'(count), 32'd4);
        check("t5_none_ready", 32'(issue_valid), 32'd0);
        set_cdb(1'b1, 6'd12, 32'h77);
        tick();
        set_cdb(1'b0, 6'd0, 32'd0);
        check("t5_wake_valid", 32'(issue_valid), 32'd1);
        check("t5_slot1_dest", 32'(issue_dest_tag), 32'd41);
        check("t5_slot1_src1", issue_src1, 32'h77);
        check("t5_slot1_src2", issue_src2, 32'hA);
        issue_ready = 1'b1;
        tick();
        check("t5_slot3_valid", 32'(issue_valid), 32'd1);
        check("t5_slot3_dest", 32'(issue_dest_tag), 32'd43);
        check("t5_slot3_op", 32'(issue_op), 32'd7);
        check("t5_slot3_src1", issue_src1, 32'hB);
        check("t5_slot3_src2", issue_src2, 32'h77);
        tick();
        issue_ready = 1'b0;
        check("t5_count_after", 32'(count), 32'd2);
        check("t5_rest_waiting", 32'(issue_valid), 32'd0);

        // Wake slot 0, then reset asynchronously mid-cycle
        set_cdb(1'b1, 6'd50, 32'h5);
        tick();
        set_cdb(1'b0, 6'd0, 32'd0);
        check("t7_slot0_ready", 32'(issue_valid), 32'd1);
        check("t7_slot0_dest", 32'(issue_dest_tag), 32'd40);
        #2;
        rst = 1'b1;
        #1;
        check("t7_rst_count", 32'(count), 32'd0);
        check("t7_rst_issue_valid", 32'(issue_valid), 32'd0);
        check("t7_rst_issue_dest", 32'(issue_dest_tag), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("t7_rst_disp_ready", 32'(disp_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
